// File: rtl/program_counter.sv
// Instruction sequencer: owns the PC, executes jump/call/return and drives the
// push/pop strobes of the instruction stack while mirroring its occupancy.
module program_counter #(
  parameter int unsigned              ADDR_WIDTH  = 16,
  parameter int unsigned              DEPTH_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0]    RESET_VEC   = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_jump,
  input  logic                   i_call,
  input  logic                   i_rtrn,
  input  logic [ADDR_WIDTH-1:0]  i_target,
  input  logic [ADDR_WIDTH-1:0]  i_stack,
  output logic [ADDR_WIDTH-1:0]  o_PC,
  output logic                   o_call,
  output logic                   o_rtrn,
  output logic                   o_ready,
  output logic [DEPTH_WIDTH:0]   o_depth,
  output logic                   o_fault
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  localparam logic [DEPTH_WIDTH:0] DEPTH_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [DEPTH_WIDTH:0]   depth_q, depth_d;
  logic                   fault_q, fault_d;
  logic                   call_strobe, rtrn_strobe;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    depth_d     = depth_q;
    fault_d     = fault_q;
    call_strobe = 1'b0;
    rtrn_strobe = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (i_en) begin
          if (i_rtrn) begin
            if (depth_q != '0) begin
              rtrn_strobe = 1'b1;
              depth_d     = depth_q - 1'b1;
              state_d     = ST_RET_WAIT;
            end else begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end
          end else if (i_call) begin
            if (depth_q != DEPTH_FULL) begin
              call_strobe = 1'b1;
              pc_d        = i_target;
              depth_d     = depth_q + 1'b1;
            end else begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end
          end else if (i_jump) begin
            pc_d = i_target;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end

      // The stack registered the return address at the pop edge; load it now.
      ST_RET_WAIT: begin
        pc_d    = i_stack;
        state_d = ST_RUN;
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  assign o_PC    = pc_q;
  assign o_call  = call_strobe;
  assign o_rtrn  = rtrn_strobe;
  assign o_ready = (state_q == ST_RUN);
  assign o_depth = depth_q;
  assign o_fault = fault_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a small behavioural instruction stack
// attached to the call/return side.
module tb_program_counter;

  localparam int AW = 16;
  localparam int DW = 4;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_en;
  logic           i_jump;
  logic           i_call;
  logic           i_rtrn;
  logic [AW-1:0]  i_target;
  logic [AW-1:0]  i_stack;
  logic [AW-1:0]  o_PC;
  logic           o_call;
  logic           o_rtrn;
  logic           o_ready;
  logic [DW:0]    o_depth;
  logic           o_fault;

  int n_checks = 0;
  int n_errors = 0;

  program_counter #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW), .RESET_VEC('0)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_jump  (i_jump),
    .i_call  (i_call),
    .i_rtrn  (i_rtrn),
    .i_target(i_target),
    .i_stack (i_stack),
    .o_PC    (o_PC),
    .o_call  (o_call),
    .o_rtrn  (o_rtrn),
    .o_ready (o_ready),
    .o_depth (o_depth),
    .o_fault (o_fault)
  );

  always #5 i_clk = ~i_clk;

  // Stack model: push o_PC on o_call, pop and present top+1 on o_rtrn.
  logic [AW-1:0] stk [16];
  int            sp;
  always @(posedge i_clk) begin
    if (i_rst) begin
      sp      <= 0;
      i_stack <= '0;
    end else if (o_call && sp < 16) begin
      stk[sp] <= o_PC;
      sp      <= sp + 1;
    end else if (o_rtrn && sp > 0) begin
      i_stack <= stk[sp-1] + 1'b1;
      sp      <= sp - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_cmds();
    i_jump = 1'b0;
    i_call = 1'b0;
    i_rtrn = 1'b0;
  endtask

  task automatic do_reset();
    clear_cmds();
    i_en  = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_target = '0;
    clear_cmds();
    step();
    step();
    check("rst_pc", o_PC, 0);
    check("rst_depth", o_depth, 0);
    check("rst_fault", o_fault, 0);
    check("rst_ready", o_ready, 1);

    // Plain increments, then wrap at 16'hFFFF.
    i_rst = 1'b0; i_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("inc_%0d", k), o_PC, k);
    end
    i_jump = 1'b1; i_target = 16'hFFFF;
    step();
    check("jump_ffff", o_PC, 16'hFFFF);
    i_jump = 1'b0;
    step();
    check("wrap_zero", o_PC, 0);

    // Single call from PC=10 and its return.
    i_jump = 1'b1; i_target = 16'd10;
    step();
    check("jump_10", o_PC, 10);
    i_jump = 1'b0; i_call = 1'b1; i_target = 16'h0040;
    settle();
    check("call_strobe", o_call, 1);
    check("call_no_rtrn", o_rtrn, 0);
    step();
    i_call = 1'b0; i_rtrn = 1'b1;
    settle();
    check("call_pc", o_PC, 16'h0040);
    check("call_depth", o_depth, 1);
    check("call_strobe_off", o_call, 0);
    check("rtrn_strobe", o_rtrn, 1);
    step();
    // RET_WAIT: commands must be ignored.
    i_rtrn = 1'b0; i_call = 1'b1; i_target = 16'h0999;
    settle();
    check("retw_ready", o_ready, 0);
    check("retw_pc_held", o_PC, 16'h0040);
    check("retw_depth", o_depth, 0);
    check("retw_no_call", o_call, 0);
    check("retw_no_rtrn", o_rtrn, 0);
    step();
    i_call = 1'b0; i_en = 1'b0;
    check("ret_pc", o_PC, 11);
    check("ret_ready", o_ready, 1);
    check("ret_depth", o_depth, 0);

    // Nine nested calls from 0x10..0x90, then nine returns.
    do_reset();
    i_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      i_jump = 1'b1; i_target = 16'(k * 16);
      step();
      i_jump = 1'b0; i_call = 1'b1; i_target = 16'(16'h0200 + k);
      settle();
      check($sformatf("nest_call_%0d", k), o_call, 1);
      step();
      i_call = 1'b0;
      check($sformatf("nest_depth_%0d", k), o_depth, k);
    end
    for (int k = 9; k >= 1; k--) begin
      i_rtrn = 1'b1;
      settle();
      check($sformatf("nest_rtrn_%0d", k), o_rtrn, 1);
      step();
      i_rtrn = 1'b0;
      check($sformatf("nest_wait_%0d", k), o_ready, 0);
      step();
      check($sformatf("nest_ret_pc_%0d", k), o_PC, k * 16 + 1);
      check($sformatf("nest_ret_depth_%0d", k), o_depth, k - 1);
    end
    i_en = 1'b0;

    // Sixteen back-to-back calls fill the stack; the seventeenth traps.
    do_reset();
    i_en = 1'b1; i_call = 1'b1;
    for (int k = 0; k < 16; k++) begin
      i_target = 16'(16'h0100 + k);
      settle();
      check($sformatf("fill_call_%0d", k), o_call, 1);
      step();
    end
    check("full_depth", o_depth, 16);
    check("full_pc", o_PC, 16'h010F);
    i_target = 16'h0AAA;
    settle();
    check("ovf_no_strobe", o_call, 0);
    step();
    check("ovf_fault", o_fault, 1);
    check("ovf_ready", o_ready, 0);
    check("ovf_pc", o_PC, 16'h010F);
    step();
    check("ovf_pc_frozen", o_PC, 16'h010F);
    check("ovf_depth_frozen", o_depth, 16);
    check("ovf_call_off", o_call, 0);
    // Reset dominates a still-asserted call.
    i_rst = 1'b1;
    step();
    i_rst = 1'b0; i_call = 1'b0; i_en = 1'b0;
    check("ovf_rst_fault", o_fault, 0);
    check("ovf_rst_pc", o_PC, 0);
    check("ovf_rst_depth", o_depth, 0);
    check("ovf_rst_ready", o_ready, 1);

    // Return with an empty stack traps without a pop.
    i_en = 1'b1; i_rtrn = 1'b1;
    settle();
    check("udf_no_strobe", o_rtrn, 0);
    step();
    check("udf_fault", o_fault, 1);
    check("udf_pc", o_PC, 0);
    check("udf_rtrn_off", o_rtrn, 0);

    // All three commands at depth 1: return wins.
    do_reset();
    i_en = 1'b1; i_jump = 1'b1; i_target = 16'h0020;
    step();
    i_jump = 1'b0; i_call = 1'b1; i_target = 16'h0050;
    step();
    i_jump = 1'b1; i_call = 1'b1; i_rtrn = 1'b1; i_target = 16'h0077;
    settle();
    check("prio_rtrn", o_rtrn, 1);
    check("prio_no_call", o_call, 0);
    step();
    clear_cmds();
    check("prio_pc_held", o_PC, 16'h0050);
    check("prio_depth", o_depth, 0);
    step();
    check("prio_ret_pc", o_PC, 16'h0021);

    // Disabled: call ignored, PC held.
    i_en = 1'b0; i_call = 1'b1; i_target = 16'h0123;
    settle();
    check("dis_no_call", o_call, 0);
    step();
    check("dis_pc_held", o_PC, 16'h0021);
    check("dis_depth", o_depth, 0);

    // Reset while in RET_WAIT.
    i_en = 1'b1; i_call = 1'b1; i_target = 16'h0300;
    step();
    i_call = 1'b0; i_rtrn = 1'b1;
    step();
    i_rtrn = 1'b0; i_rst = 1'b1;
    check("rw_pre_ready", o_ready, 0);
    step();
    i_rst = 1'b0; i_en = 1'b0;
    check("rw_rst_pc", o_PC, 0);
    check("rw_rst_ready", o_ready, 1);
    check("rw_rst_depth", o_depth, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Instruction sequencer feeding the instruction stack: holds the program counter, advances it each enabled cycle, executes jumps, and drives the call/return side of the stack interface. Calls push `o_PC` into the stack and load the target. Returns pop the stack and load the registered return address (call address + 1). A depth counter mirrors stack occupancy and traps overflow/underflow into a sticky fault state.

## Interface
- `ADDR_WIDTH`, 16: PC width; must equal the stack `DATA_WIDTH`.
- `DEPTH_WIDTH`, 4: log2 of stack entries; must equal the stack `ADDR_WIDTH`.
- `RESET_VEC`, 0: PC value after reset.

Ports:
- `i_clk`  in  1: clock, all state updates on rising edge.
- `i_rst`  in  1: synchronous, active-high reset; shared with the instruction stack.
- `i_en`  in  1: advance enable; low = hold PC, no strobes.
- `i_jump`  in  1: load `i_target`.
- `i_call`  in  1: push current PC, load `i_target`.
- `i_rtrn`  in  1: pop stack, load return address.
- `i_target`  in  ADDR_WIDTH: jump/call destination.
- `i_stack`  in  ADDR_WIDTH: stack `o_stack` (return address, already +1).
- `o_PC`  out  ADDR_WIDTH: current PC; wired to stack `i_PC`.
- `o_call`  out  1: push strobe to stack `i_call`.
- `o_rtrn`  out  1: pop strobe to stack `i_rtrn`.
- `o_ready`  out  1: high in RUN; new command accepted this cycle.
- `o_depth`  out  DEPTH_WIDTH+1: entries currently on stack, 0..2^DEPTH_WIDTH.
- `o_fault`  out  1: sticky overflow/underflow flag.

## Operation
- States: RUN, RET_WAIT, FAULT. Reset → RUN, `o_PC`=RESET_VEC, `o_depth`=0, `o_fault`=0.
- Command priority in RUN with `i_en`=1: rtrn > call > jump > increment. Lower-priority inputs are ignored in the same cycle.
- Increment: PC ← PC+1 modulo 2^ADDR_WIDTH. 2^ADDR_WIDTH−1 wraps to 0 with no flag.
- Jump: PC ← `i_target`. Depth unchanged.
- Call, `o_depth` < 2^DEPTH_WIDTH:
  - `o_call`=1 combinationally this cycle; the stack latches `o_PC` at the edge.
  - PC ← `i_target`; depth+1.
- Call with a full stack:
  - No strobe; PC held.
  - State → FAULT, `o_fault` ← 1.
- Rtrn, depth > 0:
  - `o_rtrn`=1 this cycle; depth−1; PC held.
  - State → RET_WAIT.
- RET_WAIT, exactly one cycle:
  - PC ← `i_stack`, which the stack registered at the pop edge. State → RUN.
  - All command inputs and `i_en` are ignored. `o_call`=`o_rtrn`=0.
- Rtrn with depth=0: no strobe, PC held, → FAULT, `o_fault` ← 1.
- FAULT: PC and depth frozen, strobes 0, `o_ready`=0. Exit only via `i_rst`.
- `i_en`=0 in RUN: everything holds, strobes 0.
- `o_call`/`o_rtrn` are combinational from state, `i_en`, commands and depth. They are never high outside RUN and never high together.

## Timing
- Increment/jump/call: new PC visible 1 cycle after the accepting edge.
- Return: 2 cycles. The edge that accepts rtrn issues the pop. The following edge loads `i_stack`. `o_PC` equals the return address after that second edge.
- Back-to-back commands:
  - Calls may issue every cycle.
  - A rtrn blocks acceptance for one cycle (RET_WAIT). Sustained returns therefore complete one per 2 cycles.
- Reset mid-RET_WAIT or in FAULT: the next edge gives RUN, PC=RESET_VEC, depth 0. Stack contents are discarded by the shared reset.
- Reset dominates all inputs on the same edge.

## Test plan
- Reset, `i_en`=1 with no commands for 3 cycles → `o_PC` 0,1,2,3. Force PC=16'hFFFF via jump, then increment → `o_PC`=0.
- PC=10, call with target 16'h0040:
  - `o_call` high for one cycle; next `o_PC`=16'h0040, depth 1.
  - Then rtrn: `o_rtrn` for 1 cycle, `o_ready` low for 1 cycle, then `o_PC`=11, depth 0.
- Nested calls from PCs 0x10..0x90 (9 deep), then 9 returns:
  - Return addresses 0x91, 0x81 … 0x11 in order.
  - Each return takes 2 cycles; final depth 0.
- 16 calls then a 17th → no 17th strobe, `o_fault`=1, PC frozen. Reset → `o_fault`=0, PC=0, depth 0.
- Rtrn at depth 0 → `o_fault`=1, `o_rtrn` never asserted.
- Simultaneous `i_jump`+`i_call`+`i_rtrn` at depth 1 → only `o_rtrn` fires. `i_en`=0 with `i_call`=1 → no strobe, PC held.
